vector_recorder: RTL and testbench

- Synthesizable capture engine; the write-side counterpart of our vector-driven benches.
- Records a WIDTH-bit sample (DUT stimulus and response concatenated) every clock between a trigger and a stop, then streams the recorded vectors out over a valid/ready read port.
- Sits beside a DUT in hardware so captured vectors can be dumped and replayed later.

---
 rtl/recorder_pkg.sv | 20 ++
 rtl/recorder_mem.sv | 30 +++
 rtl/vector_recorder.sv | 135 +++++++++++++
 tb/tb_vector_recorder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/recorder_pkg.sv
// Shared types and defaults for the vector recorder: FSM state encoding
// and the default vector width / buffer depth.
package recorder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 16;

    // True when n is a legal buffer depth (power of two, at least 2).
    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/recorder_mem.sv
// Simple dual-port vector store: synchronous write, registered synchronous read.
// Contents are deliberately not reset so the array maps onto block RAM.
module recorder_mem
    import recorder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vector_recorder.sv
// Capture engine: records one sample per clock from trigger to stop (or until
// the buffer fills), then streams the recorded vectors out oldest first.
module vector_recorder
    import recorder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             trigger,
    input  logic             stop,
    input  logic [WIDTH-1:0] sample,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t           r_state;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             r_rd_valid;
    logic             r_done;
    logic [AW-1:0]    r_rd_ptr;

    logic             w_hs;
    logic             w_last;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_raddr;
    logic [AW:0]      w_count_inc;
    logic [WIDTH-1:0] w_mem_q;

    assign w_hs        = (r_state == DRAIN) && r_rd_valid && rd_ready;
    assign w_last      = r_rd_valid && ({1'b0, r_rd_ptr} == (r_count - CNT_ONE));
    assign w_we        = ((r_state == ARMED) && trigger) || (r_state == CAPTURE);
    assign w_waddr     = r_count[AW-1:0];
    assign w_count_inc = r_count + CNT_ONE;

    // Fetch one entry ahead on a handshake so back-to-back reads sustain one
    // entry per cycle; while stalled the same address is re-read, so the
    // presented data stays stable.
    assign w_raddr = w_hs ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

    recorder_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (sample),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_ptr   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_rd_valid <= 1'b0;
                    r_rd_ptr   <= '0;
                    if (arm) begin
                        r_state    <= ARMED;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                ARMED: begin
                    if (trigger) begin
                        r_count <= CNT_ONE;
                        r_state <= stop ? DRAIN : CAPTURE;
                    end else if (stop) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end
                end
                CAPTURE: begin
                    r_count <= w_count_inc;
                    if (stop) begin
                        r_state <= DRAIN;
                    end else if (w_count_inc == CNT_FULL) begin
                        r_state    <= DRAIN;
                        r_overflow <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_hs && w_last) begin
                        r_state    <= IDLE;
                        r_rd_valid <= 1'b0;
                        r_rd_ptr   <= '0;
                        r_done     <= 1'b1;
                    end else begin
                        r_rd_valid <= 1'b1;
                        if (w_hs) begin
                            r_rd_ptr <= r_rd_ptr + PTR_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_valid ? w_mem_q : '0;
    assign rd_last  = w_last;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;

endmodule

// File: tb/tb_vector_recorder.sv
// Scoreboard bench for vector_recorder: sessions push expected read-back
// entries into a queue; an independent monitor pops and compares on handshakes.
module tb_vector_recorder;

    localparam int W  = 4;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm;
    logic          trigger;
    logic          stop;
    logic [W-1:0]  sample;
    logic          rd_valid;
    logic          rd_ready;
    logic [W-1:0]  rd_data;
    logic          rd_last;
    logic [AW:0]   count;
    logic          overflow;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    vector_recorder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .arm      (arm),
        .trigger  (trigger),
        .stop     (stop),
        .sample   (sample),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .count    (count),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    int           checks = 0;
    int           errors = 0;
    logic [W:0]   exp_q[$];
    int           exp_count = 0;
    bit           exp_ovf = 1'b0;
    bit           sess_done = 1'b0;
    bit           done_exp = 1'b0;
    logic [W-1:0] stim[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queue.
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            done_exp   = 1'b0;
        end else begin
            if (done_exp || done) begin
                check("done_pulse", 32'(done), 32'(done_exp));
            end
            if (done) begin
                check("count_at_done", 32'(count), 32'(exp_count));
                check("ovf_at_done", 32'(overflow), 32'(exp_ovf));
                sess_done = 1'b1;
            end
            if (prev_stall) begin
                check("stall_valid", 32'(rd_valid), 32'd1);
                if (rd_valid) check("stall_data", 32'(rd_data), 32'(prev_data));
            end
            done_exp = 1'b0;
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry actual=%0h required=none", rd_data);
                end else begin
                    check("rd_data", 32'(rd_data), 32'(exp_q[0][W-1:0]));
                    check("rd_last", 32'(rd_last), 32'(exp_q[0][W]));
                    if (rd_ready) begin
                        done_exp = exp_q[0][W];
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
        end
    end

    // One capture session driven from stim[]; the expected contents follow
    // directly from where the stop falls relative to the buffer size.
    task automatic run_session(input int pre, input bit use_stop, input int stop_idx,
                               input int rmode, input bit noise, input int abort_after);
        int n;
        bit ovf;
        int hs;
        bit hit;
        int pat[6];
        pat = '{1, 0, 0, 1, 0, 1};
        n   = use_stop ? ((stop_idx + 1 < D) ? stop_idx + 1 : D) : D;
        ovf = !(use_stop && stop_idx < D);
        for (int i = 0; i < n; i++) exp_q.push_back({1'(i == n - 1), stim[i]});
        exp_count = n;
        exp_ovf   = ovf;
        sess_done = 1'b0;
        arm = 1'b1;
        step();
        for (int i = 0; i < pre; i++) begin
            arm = noise ? 1'($urandom % 2) : 1'b0;
            step();
        end
        for (int i = 0; i < n; i++) begin
            trigger = (i == 0) ? 1'b1 : (noise ? 1'($urandom % 2) : 1'b0);
            stop    = use_stop && (i == stop_idx);
            sample  = stim[i];
            arm     = noise ? 1'($urandom % 2) : 1'b0;
            step();
            check("capture_count", 32'(count), 32'(i + 1));
            check("capture_busy", 32'(busy), 32'd1);
            check("capture_ovf", 32'(overflow), (i == n - 1) ? 32'(ovf) : 32'd0);
        end
        trigger = 1'b0;
        stop    = 1'b0;
        arm     = 1'b0;
        hs  = 0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 200 && !sess_done; cyc++) begin
            case (rmode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = 1'($urandom % 2);
                default: rd_ready = 1'(pat[cyc % 6]);
            endcase
            sample = W'($urandom);
            if (rd_valid && rd_ready) hs++;
            step();
            if (abort_after > 0 && hs == abort_after) begin
                hit = 1'b1;
                break;
            end
        end
        rd_ready = 1'b0;
        if (hit) begin
            reset = 1'b1;
            exp_q.delete();
            step();
            reset = 1'b0;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_valid", 32'(rd_valid), 32'd0);
            check("rst_count", 32'(count), 32'd0);
        end else begin
            check("session_done", 32'(sess_done), 32'd1);
            step();
            step();
            check("count_hold", 32'(count), 32'(n));
            check("ovf_hold", 32'(overflow), 32'(ovf));
            check("idle_busy", 32'(busy), 32'd0);
            check("queue_drained", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; trigger = 1'b0; stop = 1'b0;
        rd_ready = 1'b0; sample = '0;
        step();
        step();
        check("reset_valid", 32'(rd_valid), 32'd0);
        check("reset_last", 32'(rd_last), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_data", 32'(rd_data), 32'd0);
        reset = 1'b0;
        step();

        // IDLE ignores trigger, stop and rd_ready
        trigger = 1'b1; stop = 1'b1; rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_ignore_busy", 32'(busy), 32'd0);
            check("idle_ignore_valid", 32'(rd_valid), 32'd0);
        end
        trigger = 1'b0; stop = 1'b0; rd_ready = 1'b0;
        step();

        // basic: 1..5, stop on 5
        for (int i = 0; i < 5; i++) stim[i] = W'(i + 1);
        run_session(2, 1'b1, 4, 0, 1'b0, 0);

        // overflow: incrementing samples, no stop
        for (int i = 0; i < 20; i++) stim[i] = W'(i);
        run_session(1, 1'b0, 0, 0, 1'b0, 0);

        // backpressure: A,B,C with the 1,0,0,1,0,1 ready pattern
        stim[0] = 4'hA; stim[1] = 4'hB; stim[2] = 4'hC;
        run_session(0, 1'b1, 2, 2, 1'b0, 0);

        // trigger and stop together
        stim[0] = 4'h9;
        run_session(0, 1'b1, 0, 0, 1'b0, 0);

        // abort before trigger
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        check("armed_busy", 32'(busy), 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        repeat (3) step();

        // arm noise during capture must not disturb the session
        for (int i = 0; i < 32; i++) stim[i] = W'($urandom);
        run_session(1, 1'b1, 7, 1, 1'b1, 0);

        // reset mid-drain after 2 of 5 reads, then a clean session
        for (int i = 0; i < 5; i++) stim[i] = W'($urandom);
        run_session(0, 1'b1, 4, 0, 1'b0, 2);
        for (int i = 0; i < 6; i++) stim[i] = W'($urandom);
        run_session(1, 1'b1, 5, 0, 1'b0, 0);

        // stop on the filling write (no overflow) and one past it
        for (int i = 0; i < 32; i++) stim[i] = W'($urandom);
        run_session(0, 1'b1, D - 1, 0, 1'b0, 0);
        for (int i = 0; i < 32; i++) stim[i] = W'($urandom);
        run_session(0, 1'b1, D, 1, 1'b0, 0);

        // randomized sessions
        for (int s = 0; s < 20; s++) begin
            for (int i = 0; i < 32; i++) stim[i] = W'($urandom);
            run_session(int'($urandom_range(0, 3)), 1'($urandom % 2),
                        int'($urandom_range(0, D + 3)), int'($urandom_range(0, 2)),
                        1'b1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
